// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch stage: drives a 1-cycle synchronous imem and buffers {pc, instr}
// pairs in a DEPTH-entry prefetch queue handed to decode over valid/ready.
module riscv_fetch_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       redirect_in,
    input  logic [31:0]                redirect_pc_in,
    output logic                       imem_req_out,
    output logic [31:0]                imem_addr_out,
    input  logic [31:0]                imem_data_in,
    output logic                       id_valid_out,
    input  logic                       id_ready_in,
    output logic [31:0]                id_pc_out,
    output logic [31:0]                id_instr_out,
    output logic [$clog2(DEPTH):0]     occupancy_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc_q;
    logic          req_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [31:0]   issue_addr;
    logic [CW:0]   in_use;
    logic          issue;
    logic          push;
    logic          pop;

    // Decode handshake: an entry transfers on a clock edge where id_valid_out and
    // id_ready_in are both high; the head holds steady while valid is high and
    // ready is low, and valid never drops without a transfer except on redirect.
    assign pop    = (count != '0) & id_ready_in;
    assign in_use = {1'b0, count} + {{CW{1'b0}}, req_q} - {{CW{1'b0}}, pop};
    assign issue  = rst_n_in & (redirect_in | (in_use < (CW+1)'(DEPTH)));

    assign issue_addr = redirect_in ? {redirect_pc_in[31:2], 2'b00} : fetch_pc;

    // With a 1-cycle memory the only stale response is the one landing in the
    // redirect cycle itself; the response after that belongs to the redirect target.
    assign push = req_q & ~redirect_in;

    assign imem_req_out  = issue;
    assign imem_addr_out = {2'b00, issue_addr[31:2]};
    assign id_valid_out  = (count != '0);
    assign id_pc_out     = id_valid_out ? pc_mem[rd_ptr] : 32'h0;
    assign id_instr_out  = id_valid_out ? instr_mem[rd_ptr] : NOP_INSTR;
    assign occupancy_out = count;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fetch_pc <= RESET_PC;
            req_pc_q <= 32'h0;
            req_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            req_q <= issue;
            if (issue) begin
                fetch_pc <= issue_addr + 32'd4;
                req_pc_q <= issue_addr;
            end
            if (redirect_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue payload needs no reset: heads are masked until count says they are valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc_q;
            instr_mem[wr_ptr] <= imem_data_in;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: imem model, pc-stream scoreboard,
// a redirect vector table and hand-written multi-cycle corner sequences.
module tb_riscv_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_in;
    logic        rst_n_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_data_in;
    logic        id_valid_out;
    logic        id_ready_in;
    logic [31:0] id_pc_out;
    logic [31:0] id_instr_out;
    logic [$clog2(DEPTH):0] occupancy_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int seen_200 = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] target;
        logic        ready_at;
        logic [31:0] exp_addr;
        logic [31:0] exp_head;
        logic [31:0] exp_next;
    } vec_t;
    vec_t vecs[5];

    riscv_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .redirect_in(redirect_in),
        .redirect_pc_in(redirect_pc_in),
        .imem_req_out(imem_req_out),
        .imem_addr_out(imem_addr_out),
        .imem_data_in(imem_data_in),
        .id_valid_out(id_valid_out),
        .id_ready_in(id_ready_in),
        .id_pc_out(id_pc_out),
        .id_instr_out(id_instr_out),
        .occupancy_out(occupancy_out)
    );

    // Clock / reset infrastructure
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] imem_word(input logic [31:0] waddr);
        return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // 1-cycle synchronous instruction memory
    always @(posedge clk_in) begin
        imem_data_in <= imem_req_out ? imem_word(imem_addr_out) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [31:0] start);
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Scoreboard: compare each accepted head against the expected pc stream; a
    // redirect (sampled after the same-cycle pop) restarts the expected stream.
    task automatic scoreboard();
        logic [31:0] e;
        if (!rst_n_in) return;
        if (id_valid_out && id_pc_out == 32'h200) seen_200++;
        if (id_valid_out && id_ready_in) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", id_pc_out, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", id_pc_out, e);
                chk("sb_instr", id_instr_out, imem_word({2'b00, e[31:2]}));
            end
        end
        if (redirect_in) begin
            exp_q.delete();
            push_stream({redirect_pc_in[31:2], 2'b00});
        end
    endtask

    // Driver tasks: inputs change at posedge+1, checks at posedge+2, scoreboard at negedge
    task automatic drive(input logic r, input logic [31:0] rpc, input logic rdy);
        redirect_in    = r;
        redirect_pc_in = rpc;
        id_ready_in    = rdy;
        #1;
    endtask

    task automatic step();
        @(negedge clk_in);
        scoreboard();
        @(posedge clk_in);
        #1;
    endtask

    task automatic release_reset();
        rst_n_in = 1'b1;
        exp_q.delete();
        push_stream(RESET_PC);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(imem_req_out),  32'h0);
        chk({tag, "_valid"}, 32'(id_valid_out),  32'h0);
        chk({tag, "_pc"},    id_pc_out,          32'h0);
        chk({tag, "_instr"}, id_instr_out,       NOP);
        chk({tag, "_occ"},   32'(occupancy_out), 32'h0);
    endtask

    task automatic run_fill(input string tag);
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 32'h0, 1'b1);
            chk({tag, "_req"},   32'(imem_req_out), 32'h1);
            chk({tag, "_addr"},  imem_addr_out, (RESET_PC >> 2) + 32'(c));
            chk({tag, "_valid"}, 32'(id_valid_out), (c >= 2) ? 32'h1 : 32'h0);
            if (c >= 2) chk({tag, "_pc"}, id_pc_out, RESET_PC + 32'(4 * (c - 2)));
            step();
        end
    endtask

    initial begin
        logic [31:0] held_pc;
        int max_occ;
        bit found;

        vecs[0] = '{32'h0000_0100, 1'b1, 32'h0000_0040, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0103, 1'b0, 32'h0000_0040, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'hFFFF_FFFC, 1'b1, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h0000_1002, 1'b0, 32'h0000_0400, 32'h0000_1000, 32'h0000_1004};
        vecs[4] = '{32'h8000_0001, 1'b1, 32'h2000_0000, 32'h8000_0000, 32'h8000_0004};

        rst_n_in = 1'b1;
        redirect_in = 1'b0;
        redirect_pc_in = 32'h0;
        id_ready_in = 1'b1;
        #1 rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_outputs("reset");

        // Fill latency and one-per-cycle pc sequence after reset
        release_reset();
        run_fill("fill");

        // Decode stall: saturation, stable head, then gapless drain
        drive(1'b0, 32'h0, 1'b0);
        held_pc = id_pc_out;
        max_occ = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 32'h0, 1'b0);
            chk("stall_head_pc", id_pc_out, held_pc);
            if (int'(occupancy_out) > max_occ) max_occ = int'(occupancy_out);
            step();
        end
        drive(1'b0, 32'h0, 1'b0);
        chk("stall_occ_full", 32'(occupancy_out), 32'(DEPTH));
        chk("stall_max_occ", 32'(max_occ), 32'(DEPTH));
        chk("stall_no_req", 32'(imem_req_out), 32'h0);
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 32'h0, 1'b1);
            chk("drain_valid", 32'(id_valid_out), 32'h1);
            step();
        end

        // Redirect while a response is in flight into a nearly full queue
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 32'h0, 1'b0);
            if (occupancy_out == 3) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("inflight_reached", 32'(found), 32'h1);
        drive(1'b1, 32'h0000_0100, 1'b0);
        chk("inflight_req", 32'(imem_req_out), 32'h1);
        chk("inflight_addr", imem_addr_out, 32'h0000_0040);
        step();
        drive(1'b0, 32'h0, 1'b1);
        chk("inflight_t1_valid", 32'(id_valid_out), 32'h0);
        chk("inflight_t1_occ", 32'(occupancy_out), 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b1);
        chk("inflight_t2_valid", 32'(id_valid_out), 32'h1);
        chk("inflight_t2_pc", id_pc_out, 32'h0000_0100);
        step();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b1);
            step();
        end

        // Back-to-back redirects: only the second stream may surface
        seen_200 = 0;
        drive(1'b1, 32'h0000_0200, 1'b1);
        step();
        drive(1'b1, 32'h0000_0300, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        chk("dbl_gap_valid", 32'(id_valid_out), 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b1);
        chk("dbl_head_valid", 32'(id_valid_out), 32'h1);
        chk("dbl_head_pc", id_pc_out, 32'h0000_0300);
        step();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b1);
            step();
        end
        chk("dbl_never_200", 32'(seen_200), 32'h0);

        // Redirect vector table: alignment, address wrap, same-cycle pop
        for (int v = 0; v < 5; v++) begin
            for (int c = 0; c < 3; c++) begin
                drive(1'b0, 32'h0, 1'b1);
                step();
            end
            drive(1'b1, vecs[v].target, vecs[v].ready_at);
            chk("vec_req", 32'(imem_req_out), 32'h1);
            chk("vec_addr", imem_addr_out, vecs[v].exp_addr);
            step();
            drive(1'b0, 32'h0, 1'b1);
            chk("vec_t1_valid", 32'(id_valid_out), 32'h0);
            step();
            drive(1'b0, 32'h0, 1'b1);
            chk("vec_head_valid", 32'(id_valid_out), 32'h1);
            chk("vec_head_pc", id_pc_out, vecs[v].exp_head);
            step();
            drive(1'b0, 32'h0, 1'b1);
            chk("vec_next_pc", id_pc_out, vecs[v].exp_next);
            step();
        end

        // Asynchronous reset between edges, then restart from RESET_PC
        #2 rst_n_in = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        step();
        step();
        release_reset();
        run_fill("refill");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
